rx_stream_packer: RTL and testbench



---
 rtl/rx_stream_packer.sv | 199 +++++++++++++++++++
 tb/tb_rx_stream_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_stream_packer.sv
// Drains NUM_CH sample FIFOs (one channel or round-robin) into an MSB-first
// byte stream with valid/ready, prefixing every FRAME_SAMPLES samples with SYNC_BYTE.
module rx_stream_packer #(
  parameter int          NUM_CH        = 2,
  parameter int          SAMPLE_W      = 32,
  parameter int          FRAME_SAMPLES = 256,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic                         i_sys_clk,
  input  logic                         i_rst_b,
  input  logic                         i_enable,
  input  logic [NUM_CH-1:0]            i_ch_en,
  input  logic [NUM_CH-1:0]            i_fifo_empty,
  input  logic [NUM_CH-1:0]            i_fifo_full,
  input  logic [NUM_CH*SAMPLE_W-1:0]   i_fifo_data,
  output logic [NUM_CH-1:0]            o_fifo_pull,
  output logic [7:0]                   o_byte,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_overrun
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NBYTES = SAMPLE_W / 8;
  localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = $clog2(FRAME_SAMPLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PULL,
    ST_WAIT,
    ST_SHIFT
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_CH-1:0]    ch_mask_reg, ch_mask_next;
  logic [CH_W-1:0]      ch_ptr_reg, ch_ptr_next;
  logic [CNT_W-1:0]     sample_cnt_reg, sample_cnt_next;
  logic [BI_W-1:0]      byte_idx_reg, byte_idx_next;
  logic [SAMPLE_W-1:0]  shift_reg, shift_next;
  logic [7:0]           byte_reg, byte_next;
  logic                 valid_reg, valid_next;
  logic                 overrun_reg, overrun_next;
  logic                 pull_fire;
  logic                 accept;
  logic                 last_byte;
  logic                 frame_done;
  logic [SAMPLE_W-1:0]  ch_data [NUM_CH];
  logic [SAMPLE_W-1:0]  sel_data;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = CH_W'(i);
    end
  endfunction

  // Scans downward from the farthest offset so the nearest set bit above ptr
  // wins; offset NUM_CH lands back on ptr itself for a one-hot mask.
  function automatic logic [CH_W-1:0] next_set(input logic [NUM_CH-1:0] mask,
                                               input logic [CH_W-1:0]   ptr);
    next_set = ptr;
    for (int k = NUM_CH; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_CH;
      if (mask[idx]) next_set = CH_W'(idx);
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]     = i_fifo_data[gi*SAMPLE_W +: SAMPLE_W];
      assign o_fifo_pull[gi] = pull_fire && i_rst_b && (ch_ptr_reg == CH_W'(gi));
    end
  endgenerate

  assign sel_data   = ch_data[ch_ptr_reg];
  assign accept     = valid_reg && i_ready;
  assign last_byte  = (byte_idx_reg == BI_W'(NBYTES - 1));
  assign frame_done = ((sample_cnt_reg + CNT_W'(1)) == CNT_W'(FRAME_SAMPLES));

  always_comb begin
    state_next      = state_reg;
    ch_mask_next    = ch_mask_reg;
    ch_ptr_next     = ch_ptr_reg;
    sample_cnt_next = sample_cnt_reg;
    byte_idx_next   = byte_idx_reg;
    shift_next      = shift_reg;
    byte_next       = byte_reg;
    valid_next      = valid_reg;
    pull_fire       = 1'b0;
    overrun_next    = overrun_reg ||
                      ((state_reg != ST_IDLE) && (|(i_fifo_full & ch_mask_reg)));

    case (state_reg)
      ST_IDLE: begin
        if (i_enable && (|i_ch_en)) begin
          ch_mask_next    = i_ch_en;
          ch_ptr_next     = lowest_set(i_ch_en);
          sample_cnt_next = '0;
          overrun_next    = 1'b0;
          valid_next      = 1'b1;
          byte_next       = SYNC_BYTE;
          state_next      = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (accept) begin
          valid_next = 1'b0;
          state_next = ST_PULL;
        end
      end

      // Stalls on the selected channel only; skipping would break the
      // deterministic interleave order the host relies on.
      ST_PULL: begin
        if (!i_fifo_empty[ch_ptr_reg]) begin
          pull_fire  = 1'b1;
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        byte_next     = sel_data[SAMPLE_W-1 -: 8];
        shift_next    = sel_data << 8;
        byte_idx_next = '0;
        valid_next    = 1'b1;
        state_next    = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (accept) begin
          if (last_byte) begin
            valid_next  = 1'b0;
            ch_ptr_next = next_set(ch_mask_reg, ch_ptr_reg);
            if (frame_done) begin
              sample_cnt_next = '0;
              ch_mask_next    = i_ch_en;
              if (!i_enable || (i_ch_en == '0)) begin
                state_next = ST_IDLE;
              end else begin
                ch_ptr_next = lowest_set(i_ch_en);
                valid_next  = 1'b1;
                byte_next   = SYNC_BYTE;
                state_next  = ST_HEADER;
              end
            end else begin
              sample_cnt_next = sample_cnt_reg + CNT_W'(1);
              state_next      = i_enable ? ST_PULL : ST_IDLE;
            end
          end else begin
            byte_idx_next = byte_idx_reg + BI_W'(1);
            byte_next     = shift_reg[SAMPLE_W-1 -: 8];
            shift_next    = shift_reg << 8;
          end
        end
      end

      default: begin
        valid_next = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b) begin
      state_reg      <= ST_IDLE;
      ch_mask_reg    <= '0;
      ch_ptr_reg     <= '0;
      sample_cnt_reg <= '0;
      byte_idx_reg   <= '0;
      shift_reg      <= '0;
      byte_reg       <= '0;
      valid_reg      <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ch_mask_reg    <= ch_mask_next;
      ch_ptr_reg     <= ch_ptr_next;
      sample_cnt_reg <= sample_cnt_next;
      byte_idx_reg   <= byte_idx_next;
      shift_reg      <= shift_next;
      byte_reg       <= byte_next;
      valid_reg      <= valid_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign o_byte    = byte_reg;
  assign o_valid   = valid_reg;
  assign o_busy    = (state_reg != ST_IDLE);
  assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_rx_stream_packer.sv
// Directed bench for rx_stream_packer: two queue-backed FIFOs, a byte
// capture monitor and hand-written expected byte streams.
module tb_rx_stream_packer;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  ch_en = 2'b00;
  logic [1:0]  fifo_empty = 2'b11;
  logic [1:0]  fifo_full = 2'b00;
  logic [63:0] fifo_data = '0;
  logic [1:0]  fifo_pull;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        ready = 1'b1;
  logic        busy;
  logic        overrun;

  rx_stream_packer #(
    .NUM_CH(2), .SAMPLE_W(32), .FRAME_SAMPLES(4), .SYNC_BYTE(8'hA5)
  ) dut (
    .i_sys_clk(clk), .i_rst_b(rst_b), .i_enable(enable), .i_ch_en(ch_en),
    .i_fifo_empty(fifo_empty), .i_fifo_full(fifo_full), .i_fifo_data(fifo_data),
    .o_fifo_pull(fifo_pull), .o_byte(out_byte), .o_valid(out_valid),
    .i_ready(ready), .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int pulls0 = 0, pulls1 = 0, bad_pulls = 0;

  // FIFO model: read data appears one cycle after the pull strobe.
  always @(posedge clk) begin
    if (fifo_pull[0]) begin
      if (q0.size() == 0) bad_pulls++;
      else begin fifo_data[31:0] <= q0.pop_front(); pulls0++; end
    end
    if (fifo_pull[1]) begin
      if (q1.size() == 0) bad_pulls++;
      else begin fifo_data[63:32] <= q1.pop_front(); pulls1++; end
    end
    fifo_empty[0] <= (q0.size() == 0);
    fifo_empty[1] <= (q1.size() == 0);
  end

  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;

  always @(negedge clk) begin
    if (rst_b && prev_stall && (!out_valid || out_byte != prev_byte)) stab_err++;
    prev_stall = out_valid && !ready && rst_b;
    prev_byte  = out_byte;
    if (out_valid && ready && rst_b) cap.push_back(out_byte);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    for (int c = 0; c < 2000 && cap.size() < n; c++) tick();
    check(tag, cap.size(), n);
  endtask

  task automatic add_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic compare_stream(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < cap.size()) ? cap[i] : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    enable = 1'b0;
    ch_en = 2'b00;
    fifo_full = 2'b00;
    rand_ready = 1'b0;
    q0.delete();
    q1.delete();
    repeat (3) tick();
    cap.delete();
    exp_q.delete();
    rst_b = 1'b1;
  endtask

  int b0, b1, bs;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_byte", {24'd0, out_byte}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_pull", {30'd0, fifo_pull}, 0);

    // Single channel: header latency, byte order, single pull
    @(posedge clk); #1;
    cap.delete();
    b0 = pulls0;
    q0.push_back(32'h5AC3E7F1);
    ch_en = 2'b01;
    enable = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_hdr_latency", {23'd0, out_valid, out_byte}, {23'd0, 1'b1, 8'hA5});
    #1;
    wait_bytes("t1_hdr", 1);
    enable = 1'b0;
    wait_bytes("t1_count", 5);
    exp_q = '{8'hA5, 8'h5A, 8'hC3, 8'hE7, 8'hF1};
    compare_stream("t1");
    repeat (3) tick();
    check("t1_pulls", pulls0 - b0, 1);
    check("t1_idle", {31'd0, busy}, 0);

    // Round-robin interleave across a 4-sample frame
    do_reset();
    b0 = pulls0; b1 = pulls1;
    q0.push_back(32'h11111111); q0.push_back(32'h33333333);
    q1.push_back(32'h22222222); q1.push_back(32'h44444444);
    ch_en = 2'b11;
    enable = 1'b1;
    wait_bytes("t2_count", 18);
    exp_q.push_back(8'hA5);
    add_word(32'h11111111); add_word(32'h22222222);
    add_word(32'h33333333); add_word(32'h44444444);
    exp_q.push_back(8'hA5);
    compare_stream("t2");
    repeat (10) tick();
    check("t2_no_extra", cap.size(), 18);
    check("t2_pulls0", pulls0 - b0, 2);
    check("t2_pulls1", pulls1 - b1, 2);
    check("t2_busy", {31'd0, busy}, 1);

    // Empty stall on ch1, then late arrival
    do_reset();
    b0 = pulls0; b1 = pulls1;
    q0.push_back(32'hCAFEBABE);
    ch_en = 2'b11;
    enable = 1'b1;
    wait_bytes("t3_first", 5);
    repeat (20) tick();
    check("t3_stall_len", cap.size(), 5);
    check("t3_no_repull", pulls0 - b0, 1);
    check("t3_busy_stall", {31'd0, busy}, 1);
    q1.push_back(32'h0BADF00D);
    enable = 1'b0;
    wait_bytes("t3_count", 9);
    exp_q = '{8'hA5, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
    compare_stream("t3");
    repeat (3) tick();
    check("t3_idle", {31'd0, busy}, 0);
    check("t3_pulls1", pulls1 - b1, 1);

    // Random backpressure: same stream as the round-robin run
    do_reset();
    bs = stab_err;
    rand_ready = 1'b1;
    q0.push_back(32'h11111111); q0.push_back(32'h33333333);
    q1.push_back(32'h22222222); q1.push_back(32'h44444444);
    ch_en = 2'b11;
    enable = 1'b1;
    wait_bytes("t4_count", 18);
    exp_q.push_back(8'hA5);
    add_word(32'h11111111); add_word(32'h22222222);
    add_word(32'h33333333); add_word(32'h44444444);
    exp_q.push_back(8'hA5);
    compare_stream("t4");
    check("t4_stable", stab_err - bs, 0);
    rand_ready = 1'b0;

    // Mask change mid-frame, then disable mid-sample
    do_reset();
    b0 = pulls0; b1 = pulls1;
    ch_en = 2'b01;
    q0.push_back(32'h01020304); q0.push_back(32'h05060708);
    q0.push_back(32'h090A0B0C); q0.push_back(32'h0D0E0F10);
    q1.push_back(32'hA1B2C3D4);
    enable = 1'b1;
    wait_bytes("t5_hdr", 1);
    ch_en = 2'b10;
    wait_bytes("t5_mid", 20);
    enable = 1'b0;
    wait_bytes("t5_count", 22);
    exp_q.push_back(8'hA5);
    add_word(32'h01020304); add_word(32'h05060708);
    add_word(32'h090A0B0C); add_word(32'h0D0E0F10);
    exp_q.push_back(8'hA5);
    add_word(32'hA1B2C3D4);
    compare_stream("t5");
    repeat (3) tick();
    check("t5_idle", {31'd0, busy}, 0);
    check("t5_pulls0", pulls0 - b0, 4);
    check("t5_pulls1", pulls1 - b1, 1);

    // Overrun: masked-off full ignored, sticky, cleared on restart
    do_reset();
    b0 = pulls0;
    ch_en = 2'b01;
    q0.push_back(32'h12345678);
    fifo_full = 2'b10;
    enable = 1'b1;
    repeat (3) tick();
    check("t6_ovr_masked", {31'd0, overrun}, 0);
    fifo_full = 2'b01;
    repeat (2) tick();
    check("t6_ovr_set", {31'd0, overrun}, 1);
    fifo_full = 2'b00;
    repeat (2) tick();
    check("t6_ovr_sticky", {31'd0, overrun}, 1);
    enable = 1'b0;
    wait_bytes("t6_count", 5);
    repeat (3) tick();
    check("t6_idle", {31'd0, busy}, 0);
    check("t6_ovr_idle", {31'd0, overrun}, 1);
    q0.push_back(32'h87654321);
    enable = 1'b1;
    tick();
    check("t6_ovr_clear", {31'd0, overrun}, 0);

    // Reset in the middle of a sample
    wait_bytes("t6_shift", 7);
    rst_b = 1'b0;
    enable = 1'b0;
    tick();
    check("t6_rst_valid", {31'd0, out_valid}, 0);
    check("t6_rst_byte", {24'd0, out_byte}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    check("t6_rst_pull", {30'd0, fifo_pull}, 0);
    check("t6_pulls0", pulls0 - b0, 2);
    rst_b = 1'b1;
    repeat (2) tick();

    check("no_empty_pull", bad_pulls, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
